// File: rtl/host_uart_pkg.sv
// Shared types and helpers for the host UART receiver.
// The PARITY encoding is always reserved so the state encoding does not
// depend on whether HOST_UART_RX_PARITY_EN is defined.
package host_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP    = 3'd4,
    ST_ERRWAIT = 3'd5
  } rx_state_e;

  // One width serves both the baud counter and the idle timer. The idle
  // limit is always at least one bit-time, so it sets the width.
  function automatic int cnt_width(input int clks_per_bit, input int idle_timeout);
    return $clog2(clks_per_bit * idle_timeout + 1);
  endfunction

endpackage

// File: rtl/host_rx_fifo.sv
// Synchronous first-word-fall-through byte FIFO. The head byte is read
// combinationally from storage and forced to zero while empty.
module host_rx_fifo
  import host_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          push,
  input  logic [7:0]                    wdata,
  input  logic                          pop,
  output logic [7:0]                    rdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == LVL_FULL);
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = empty ? 8'h00 : mem[rd_ptr];
  assign level   = count;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + LVL_ONE;
        2'b01:   count <= count - LVL_ONE;
        default: count <= count;
      endcase
    end
  end

  // Byte storage; contents are meaningless while not counted in level.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/host_uart_rx.sv
// Host UART receiver: 8N1 deserialiser, FWFT byte buffer and load-session
// idle timer driving done_o.
// Optional macro HOST_UART_RX_PARITY_EN switches the frame to 8E1 and adds
// the sticky parity_err_o port.
module host_uart_rx
  import host_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int IDLE_TIMEOUT = 20
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          rx_i,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  input  logic                          ack_i,
  output logic                          done_o,
  output logic                          frame_err_o,
  output logic                          overflow_o,
`ifdef HOST_UART_RX_PARITY_EN
  output logic                          parity_err_o,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int CW = cnt_width(CLKS_PER_BIT, IDLE_TIMEOUT);
  localparam logic [CW-1:0] HALF_BIT   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] IDLE_LIMIT = CW'(IDLE_TIMEOUT * CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  logic          rx_p0, rx_p1, rx_p2;
  logic          rxs, fall;
  rx_state_e     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic [CW-1:0] idle_cnt, idle_n;
  logic          sess_done, sess_done_n;
  logic          ferr, ferr_n;
  logic          ovf, ovf_n;
  logic          push, pop;
  logic          fifo_full, fifo_empty;
`ifdef HOST_UART_RX_PARITY_EN
  logic          par_bad, par_bad_n;
  logic          perr, perr_n;
`endif

  // Two-flop synchroniser plus one history flop for start-edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx_i;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  assign rxs  = rx_p1;
  assign fall = rx_p2 & ~rx_p1;

  // Control state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      idle_cnt  <= '0;
      sess_done <= 1'b1;
      ferr      <= 1'b0;
      ovf       <= 1'b0;
`ifdef HOST_UART_RX_PARITY_EN
      par_bad   <= 1'b0;
      perr      <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_n;
      idle_cnt  <= idle_n;
      sess_done <= sess_done_n;
      ferr      <= ferr_n;
      ovf       <= ovf_n;
`ifdef HOST_UART_RX_PARITY_EN
      par_bad   <= par_bad_n;
      perr      <= perr_n;
`endif
    end
  end

  // Shift register holds data only; a partial byte is never pushed.
  always_ff @(posedge clk_i) begin
    shift <= shift_n;
  end

  // Next-state, bit sampling, idle timer and sticky error flags.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_n       = bit_idx;
    shift_n     = shift;
    push        = 1'b0;
    ferr_n      = ferr;
    sess_done_n = sess_done;
    idle_n      = '0;
`ifdef HOST_UART_RX_PARITY_EN
    par_bad_n   = par_bad;
    perr_n      = perr;
`endif

    // Idle timer first so that a start edge in the same cycle wins.
    if (state == ST_IDLE && rxs) begin
      idle_n = (idle_cnt == IDLE_LIMIT) ? idle_cnt : idle_cnt + CNT_ONE;
    end
    if (idle_cnt == IDLE_LIMIT) sess_done_n = 1'b1;

    case (state)
      ST_IDLE: begin
        if (fall) begin
          state_n     = ST_START;
          cnt_n       = HALF_BIT;
          sess_done_n = 1'b0;
        end
      end
      ST_START: begin
        if (cnt == '0) begin
          if (rxs) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_DATA;
            bit_n   = '0;
            cnt_n   = FULL_BIT;
          end
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt == '0) begin
          shift_n = {rxs, shift[7:1]};
          cnt_n   = FULL_BIT;
          bit_n   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef HOST_UART_RX_PARITY_EN
            state_n = ST_PARITY;
`else
            state_n = ST_STOP;
`endif
          end
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
`ifdef HOST_UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt == '0) begin
          par_bad_n = rxs ^ (^shift);
          cnt_n     = FULL_BIT;
          state_n   = ST_STOP;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
`endif
      ST_STOP: begin
        if (cnt == '0) begin
          if (rxs) begin
            state_n = ST_IDLE;
`ifdef HOST_UART_RX_PARITY_EN
            push    = !par_bad;
            if (par_bad) perr_n = 1'b1;
`else
            push    = 1'b1;
`endif
          end else begin
            ferr_n  = 1'b1;
            state_n = ST_ERRWAIT;
          end
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      ST_ERRWAIT: begin
        if (rxs) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    ovf_n = ovf | (push && fifo_full && !pop);
  end

  assign pop = valid_o && ack_i;

  host_rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .wdata (shift),
    .pop   (pop),
    .rdata (data_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_o)
  );

  assign valid_o     = ~fifo_empty;
  assign done_o      = sess_done & fifo_empty;
  assign frame_err_o = ferr;
  assign overflow_o  = ovf;
`ifdef HOST_UART_RX_PARITY_EN
  assign parity_err_o = perr;
`endif

endmodule

// File: tb/tb_host_uart_rx.sv
// Bench for host_uart_rx: directed scenarios plus random bytes, with a
// queue-based scoreboard drained by an independent monitor process.
module tb_host_uart_rx;

  localparam int CLKS  = 16;
  localparam int DEPTH = 4;
  localparam int TMO   = 4;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       rx_i;
  logic       ack_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       done_o;
  logic       frame_err_o;
  logic       overflow_o;
  logic [2:0] level_o;

  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         rise_cyc = -1;
  int         fall_cyc = -1;
  int         t0;
  int         d;
  bit         auto_ack = 1'b0;
  bit         exp_ferr = 1'b0;
  bit         exp_ovf = 1'b0;
  logic [7:0] exp_q [$];
  logic [7:0] rb;

  host_uart_rx #(
    .CLKS_PER_BIT(CLKS),
    .FIFO_DEPTH  (DEPTH),
    .IDLE_TIMEOUT(TMO)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rx_i       (rx_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ack_i      (ack_i),
    .done_o     (done_o),
    .frame_err_o(frame_err_o),
    .overflow_o (overflow_o),
    .level_o    (level_o)
  );

  initial forever #5 clk_i = ~clk_i;

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: records output edges and, when enabled, pops and checks bytes.
  initial begin
    bit pv;
    bit pd;
    pv = 1'b0;
    pd = 1'b1;
    ack_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (valid_o && !pv) rise_cyc = cyc;
      if (!done_o && pd) fall_cyc = cyc;
      pv = valid_o;
      pd = done_o;
      if (auto_ack && valid_o && !rst_i) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_byte: actual=%02h required=no byte", data_o);
        end else begin
          check("rx_byte", {24'h0, data_o}, {24'h0, exp_q.pop_front()});
        end
        ack_i = 1'b1;
      end else begin
        ack_i = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached with %0d failures", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic bit_time(input logic v);
    rx_i = v;
    wait_cycles(CLKS);
  endtask

  // Serial frame; the model decides the byte's fate as the stop bit begins.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    if (stop) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else exp_ovf = 1'b1;
    end else begin
      exp_ferr = 1'b1;
    end
    bit_time(stop);
    rx_i = 1'b1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk_i);
    wait_cycles(2);
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk_i);
    check({tag, "_data"}, {24'h0, data_o}, 0);
    check({tag, "_valid"}, {31'h0, valid_o}, 0);
    check({tag, "_done"}, {31'h0, done_o}, 1);
    check({tag, "_frame_err"}, {31'h0, frame_err_o}, 0);
    check({tag, "_overflow"}, {31'h0, overflow_o}, 0);
    check({tag, "_level"}, {29'h0, level_o}, 0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    rx_i  = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check_reset_vals("reset");

    // Single byte: valid appears just after the mid-stop sample.
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    d = rise_cyc - t0;
    check("t1_valid_latency_in_window", {31'h0, (d >= 152 && d <= 157)}, 1);
    @(negedge clk_i);
    check("t1_valid", {31'h0, valid_o}, 1);
    check("t1_data", {24'h0, data_o}, 32'hA5);
    check("t1_level", {29'h0, level_o}, 1);
    @(posedge clk_i);
    #1;
    auto_ack = 1'b1;
    wait_drain();
    @(negedge clk_i);
    check("t1_valid_after_ack", {31'h0, valid_o}, 0);
    check("t1_level_after_ack", {29'h0, level_o}, 0);
    @(posedge clk_i);
    #1;

    // Short low glitch is rejected.
    rx_i = 1'b0;
    wait_cycles(5);
    rx_i = 1'b1;
    wait_cycles(3 * CLKS);
    check("t2_level", {29'h0, level_o}, 0);
    check("t2_valid", {31'h0, valid_o}, 0);
    wait_cycles(100);
    check("t2_done", {31'h0, done_o}, 1);

    // Low stop bit, then a clean byte.
    send_frame(8'h3C, 1'b0);
    wait_cycles(4);
    check("t3_frame_err", {31'h0, frame_err_o}, {31'h0, exp_ferr});
    check("t3_level", {29'h0, level_o}, 0);
    send_frame(8'h11, 1'b1);
    wait_drain();

    // Overflow with the consumer stalled.
    auto_ack = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      rb = 8'(i);
      send_frame(rb, 1'b1);
    end
    wait_cycles(CLKS);
    check("t4_level", {29'h0, level_o}, 4);
    check("t4_head", {24'h0, data_o}, 32'h01);
    check("t4_valid", {31'h0, valid_o}, 1);
    check("t4_overflow", {31'h0, overflow_o}, {31'h0, exp_ovf});
    auto_ack = 1'b1;
    wait_drain();
    check("t4_level_drained", {29'h0, level_o}, 0);

    // Session end: done drops at the first start bit, returns after
    // timeout and drain.
    wait_cycles(100);
    check("t5_done_before", {31'h0, done_o}, 1);
    auto_ack = 1'b0;
    t0 = cyc;
    send_frame(8'h10, 1'b1);
    d = fall_cyc - t0;
    check("t5_done_fall_in_window", {31'h0, (d >= 1 && d <= 5)}, 1);
    send_frame(8'h20, 1'b1);
    wait_cycles(20);
    check("t5_done_short_idle", {31'h0, done_o}, 0);
    wait_cycles(80);
    check("t5_done_not_drained", {31'h0, done_o}, 0);
    check("t5_level", {29'h0, level_o}, 2);
    auto_ack = 1'b1;
    wait_drain();
    check("t5_done_after", {31'h0, done_o}, 1);

    // Reset in the middle of data bit 4 with a byte already buffered.
    auto_ack = 1'b0;
    send_frame(8'h77, 1'b1);
    rb = 8'hC3;
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(rb[i]);
    rx_i = rb[4];
    wait_cycles(8);
    rst_i = 1'b1;
    rx_i  = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    exp_q.delete();
    exp_ferr = 1'b0;
    exp_ovf  = 1'b0;
    check_reset_vals("t6");
    auto_ack = 1'b1;
    wait_cycles(2 * CLKS);
    send_frame(8'h5A, 1'b1);
    wait_drain();

    // Random bytes, occasional bad stop bits, random gaps.
    for (int n = 0; n < 20; n++) begin
      rb = 8'($urandom);
      send_frame(rb, ($urandom_range(0, 7) != 0));
      wait_cycles(int'($urandom_range(0, 2 * CLKS)));
    end
    wait_drain();
    check("rand_frame_err", {31'h0, frame_err_o}, {31'h0, exp_ferr});
    check("rand_overflow", {31'h0, overflow_o}, {31'h0, exp_ovf});
    check("rand_level", {29'h0, level_o}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
